// File: rtl/scoreboard_seg_scan.sv
// scoreboard_seg_scan: scans the 32-bit scoreboard word {user_id, score} onto an 8-digit
// common-anode seven-segment display, with a tear-free shadow copy and end-of-list blinking.
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zeros of each 16-bit half.
module scoreboard_seg_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display_data,
    input  logic        scoreboard_eof,
    output logic [7:0]  digit_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PCNT_PRE  = PW'(REFRESH_DIV - 2);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] r_pcnt;
    logic [2:0]    r_idx;
    logic          r_frame_done;
    logic [31:0]   r_sh;
    logic [BW-1:0] r_bcnt;
    logic          r_phase_on;

    logic          w_tick;
    logic          w_show;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_next;

    // Active-low segment pattern for one hex nibble (bit 0 = a ... bit 6 = g).
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] w_half;

    // A digit is a leading zero when it and every nibble above it in its half are zero.
    function automatic logic lead_blank(input logic [15:0] half, input logic [1:0] pos);
        logic blank;
        case (pos)
            2'd1:    blank = (half[15:4] == 12'h000);
            2'd2:    blank = (half[15:8] == 8'h00);
            2'd3:    blank = (half[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

    assign w_half = r_idx[2] ? r_sh[31:16] : r_sh[15:0];
`endif

    assign w_tick     = (r_pcnt == PCNT_LAST);
    // Dropping eof shows the display immediately, without waiting for the phase register.
    assign w_show     = r_phase_on | ~scoreboard_eof;
    assign frame_done = r_frame_done;

    // Prescaler, digit index and a frame_done pulse registered one cycle ahead of the slot end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt       <= '0;
            r_idx        <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pcnt <= '0;
                r_idx  <= r_idx + 3'd1;
            end else begin
                r_pcnt <= r_pcnt + PW'(1);
                r_idx  <= r_idx;
            end
            r_frame_done <= (r_pcnt == PCNT_PRE) && (r_idx == 3'd7);
        end
    end

    // Shadow copy only changes at a frame boundary so a frame is never torn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= 32'h0000_0000;
        end else if (r_frame_done) begin
            r_sh <= display_data;
        end else begin
            r_sh <= r_sh;
        end
    end

    // Blink phase: toggles every BLINK_FRAMES frames while eof is high, forced ON otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt     <= '0;
            r_phase_on <= 1'b1;
        end else if (!scoreboard_eof) begin
            r_bcnt     <= '0;
            r_phase_on <= 1'b1;
        end else if (r_frame_done) begin
            if (r_bcnt == BCNT_LAST) begin
                r_bcnt     <= '0;
                r_phase_on <= ~r_phase_on;
            end else begin
                r_bcnt     <= r_bcnt + BW'(1);
                r_phase_on <= r_phase_on;
            end
        end else begin
            r_bcnt     <= r_bcnt;
            r_phase_on <= r_phase_on;
        end
    end

    // Segment pattern for the digit currently being scanned.
    always_comb begin
        w_nibble   = r_sh[{r_idx, 2'b00} +: 4];
        w_seg_next = hex7(w_nibble);
`ifdef LEADING_ZERO_BLANK_EN
        if (lead_blank(w_half, r_idx[1:0])) begin
            w_seg_next = 7'h7F;
        end else begin
            w_seg_next = hex7(w_nibble);
        end
`endif
    end

    // Registered pin drivers; blink OFF phase darkens everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_en <= 8'hFF;
            seg      <= 7'h7F;
            dp       <= 1'b1;
        end else if (!w_show) begin
            digit_en <= 8'hFF;
            seg      <= 7'h7F;
            dp       <= 1'b1;
        end else begin
            digit_en <= ~(8'h01 << r_idx);
            seg      <= w_seg_next;
            dp       <= (r_idx == 3'd4) ? 1'b0 : 1'b1;
        end
    end

endmodule

// File: tb/tb_scoreboard_seg_scan.sv
// Self-checking bench for scoreboard_seg_scan with an arithmetic cycle-level reference model.
module tb_scoreboard_seg_scan;

    localparam int DIV   = 4;
    localparam int BF    = 2;
    localparam int FRAME = 8 * DIV;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        eof  = 1'b0;
    logic [31:0] data = 32'h0;
    logic [7:0]  digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles since reset, shadow word, frames counted while eof is high.
    int          m_t      = 0;
    int          m_frames = 0;
    logic [31:0] m_sh     = 32'h0;
    logic [7:0]  e_den    = 8'hFF;
    logic [6:0]  e_seg    = 7'h7F;
    logic        e_dp     = 1'b1;
    logic        e_fd     = 1'b0;

    scoreboard_seg_scan #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .clk           (clk),
        .rst           (rst),
        .display_data  (data),
        .scoreboard_eof(eof),
        .digit_en      (digit_en),
        .seg           (seg),
        .dp            (dp),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    // Lit segments of each hex glyph, by segment letter.
    function automatic logic [6:0] shape(input int h);
        string s;
        logic [6:0] r;
        case (h)
            0:  s = "abcdef";
            1:  s = "bc";
            2:  s = "abdeg";
            3:  s = "abcdg";
            4:  s = "bcfg";
            5:  s = "acdfg";
            6:  s = "acdefg";
            7:  s = "abc";
            8:  s = "abcdefg";
            9:  s = "abcdfg";
            10: s = "abcefg";
            11: s = "cdefg";
            12: s = "adef";
            13: s = "bcdeg";
            14: s = "adefg";
            15: s = "aefg";
            default: s = "";
        endcase
        r = 7'h7F;
        for (int k = 0; k < s.len(); k++) r[3'(int'(s[k]) - 97)] = 1'b0;
        return r;
    endfunction

    function automatic logic [6:0] digit_shape(input logic [31:0] sh, input int i);
        int nib;
`ifdef LEADING_ZERO_BLANK_EN
        int half;
        int p;
        half = (i < 4) ? int'(sh[15:0]) : int'(sh[31:16]);
        p    = i % 4;
        if (p > 0 && (half >> (4 * p)) == 0) return 7'h7F;
`endif
        nib = int'((sh >> (4 * i)) & 32'hF);
        return shape(nib);
    endfunction

    // Advance one clock, update the model with the inputs seen at that edge, settle.
    task automatic step();
        int idx;
        logic [7:0] one8;
        @(posedge clk);
        one8 = 8'd1;
        if (rst) begin
            e_den = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            m_t = 0; m_sh = 32'h0; m_frames = 0;
        end else begin
            idx = (m_t / DIV) % 8;
            if (!eof || ((m_frames / BF) % 2) == 0) begin
                e_den = ~(one8 << idx);
                e_seg = digit_shape(m_sh, idx);
                e_dp  = (idx == 4) ? 1'b0 : 1'b1;
            end else begin
                e_den = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            if (!eof) m_frames = 0;
            else if (e_fd) m_frames++;
            if (e_fd) m_sh = data;
            m_t++;
            e_fd = ((m_t % FRAME) == FRAME - 1);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if ({digit_en, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold got %h/%h/%b/%b required ff/7f/1/0", digit_en, seg, dp, frame_done);
            end
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (digit_en !== 8'hFE || seg !== 7'h40) begin
            n_fail++;
            $display("FAIL reset_release got den=%h seg=%h required fe/40", digit_en, seg);
        end
    endtask

    task automatic test_scan();
        int fd_cnt = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (frame_done === 1'b1) fd_cnt++;
            n_tests++;
            if ({digit_en, seg, dp, frame_done} !== {e_den, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL scan got %h required %h", {digit_en, seg, dp, frame_done}, {e_den, e_seg, e_dp, e_fd});
            end
        end
        n_tests++;
        if (fd_cnt != 2) begin
            n_fail++;
            $display("FAIL scan_fd_count got %0d required 2", fd_cnt);
        end
    endtask

    task automatic test_shadow();
        logic [6:0] cap_seg [8];
        logic       cap_dp  [8];
        logic [7:0] one8;
        int         k;
        int         dig  [5];
        logic [6:0] want [5];
        one8 = 8'd1;
        for (int i = 0; i < 8; i++) begin cap_seg[i] = 7'h00; cap_dp[i] = 1'b1; end
        k = 0;
        while (((m_t / DIV) % 8) != 2 && k < FRAME + 8) begin step(); k++; end
        data = 32'h1234_00A5;
        k = 0;
        do begin
            step(); k++;
            n_tests++;
            if ({digit_en, seg, dp, frame_done} !== {e_den, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL shadow_hold got %h required %h", {digit_en, seg, dp, frame_done}, {e_den, e_seg, e_dp, e_fd});
            end
        end while (e_fd !== 1'b1 && k < FRAME + 8);
        n_tests++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL shadow_fd_wait got frame_done=%b required 1", frame_done);
        end
        for (int c = 0; c <= FRAME; c++) begin
            step();
            n_tests++;
            if ({digit_en, seg, dp, frame_done} !== {e_den, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL shadow_show got %h required %h", {digit_en, seg, dp, frame_done}, {e_den, e_seg, e_dp, e_fd});
            end
            if (c > 0) for (int i = 0; i < 8; i++)
                if (digit_en == ~(one8 << i)) begin cap_seg[i] = seg; cap_dp[i] = dp; end
        end
        dig = '{0, 1, 2, 4, 7};
`ifdef LEADING_ZERO_BLANK_EN
        want = '{7'h12, 7'h08, 7'h7F, 7'h19, 7'h79};
`else
        want = '{7'h12, 7'h08, 7'h40, 7'h19, 7'h79};
`endif
        for (int j = 0; j < 5; j++) begin
            n_tests++;
            if (cap_seg[dig[j]] !== want[j]) begin
                n_fail++;
                $display("FAIL shadow_digit%0d got seg=%h required %h", dig[j], cap_seg[dig[j]], want[j]);
            end
        end
        n_tests++;
        if (cap_dp[4] !== 1'b0 || cap_dp[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL shadow_dp got d4=%b d0=%b required 0/1", cap_dp[4], cap_dp[0]);
        end
    endtask

    task automatic test_blink();
        int k;
        int dark = 0;
        k = 0;
        while (e_fd !== 1'b1 && k < FRAME + 8) begin step(); k++; end
        eof = 1'b1;
        for (int c = 1; c <= 4 * FRAME; c++) begin
            step();
            if (digit_en === 8'hFF) dark++;
            n_tests++;
            if ({digit_en, seg, dp, frame_done} !== {e_den, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL blink c=%0d got %h required %h", c, {digit_en, seg, dp, frame_done}, {e_den, e_seg, e_dp, e_fd});
            end
        end
        n_tests++;
        if (dark != 2 * FRAME) begin
            n_fail++;
            $display("FAIL blink_dark_count got %0d required %0d", dark, 2 * FRAME);
        end
        k = 0;
        while (e_den !== 8'hFF && k < 3 * FRAME) begin step(); k++; end
        repeat (10) step();
        n_tests++;
        if (digit_en !== 8'hFF) begin
            n_fail++;
            $display("FAIL blink_off_phase got den=%h required ff", digit_en);
        end
        eof = 1'b0;
        step();
        n_tests++;
        if (digit_en === 8'hFF || digit_en !== e_den || seg !== e_seg) begin
            n_fail++;
            $display("FAIL blink_eof_drop got den=%h seg=%h required %h/%h", digit_en, seg, e_den, e_seg);
        end
    endtask

    task automatic test_blank();
        logic [6:0] cap_seg [8];
        logic       cap_dp  [8];
        logic [6:0] want;
        logic [7:0] one8;
        int         k;
        one8 = 8'd1;
        for (int i = 0; i < 8; i++) begin cap_seg[i] = 7'h00; cap_dp[i] = 1'b1; end
        data = 32'h0007_0000;
        k = 0;
        while (e_fd !== 1'b1 && k < FRAME + 8) begin step(); k++; end
        for (int c = 0; c <= FRAME; c++) begin
            step();
            n_tests++;
            if ({digit_en, seg, dp, frame_done} !== {e_den, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL blank_scan got %h required %h", {digit_en, seg, dp, frame_done}, {e_den, e_seg, e_dp, e_fd});
            end
            if (c > 0) for (int i = 0; i < 8; i++)
                if (digit_en == ~(one8 << i)) begin cap_seg[i] = seg; cap_dp[i] = dp; end
        end
        for (int i = 0; i < 8; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            want = (i == 4) ? 7'h78 : ((i == 0) ? 7'h40 : 7'h7F);
`else
            want = (i == 4) ? 7'h78 : 7'h40;
`endif
            n_tests++;
            if (cap_seg[i] !== want) begin
                n_fail++;
                $display("FAIL blank_digit%0d got seg=%h required %h", i, cap_seg[i], want);
            end
        end
        n_tests++;
        if (cap_dp[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_dp4 got %b required 0", cap_dp[4]);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        while (((m_t / DIV) % 8) != 5 && k < FRAME + 8) begin step(); k++; end
        rst = 1'b1;
        step();
        n_tests++;
        if ({digit_en, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid got %h/%h/%b/%b required ff/7f/1/0", digit_en, seg, dp, frame_done);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (digit_en !== 8'hFE || seg !== 7'h40) begin
            n_fail++;
            $display("FAIL reset_mid_restart got den=%h seg=%h required fe/40", digit_en, seg);
        end
        for (int c = 0; c < FRAME + 8; c++) begin
            step();
            n_tests++;
            if ({digit_en, seg, dp, frame_done} !== {e_den, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL reset_mid_scan got %h required %h", {digit_en, seg, dp, frame_done}, {e_den, e_seg, e_dp, e_fd});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 8 * FRAME; c++) begin
            if ($urandom_range(7) == 0) data = $urandom;
            if ($urandom_range(40) == 0) eof = ~eof;
            step();
            n_tests++;
            if ({digit_en, seg, dp, frame_done} !== {e_den, e_seg, e_dp, e_fd}) begin
                n_fail++;
                $display("FAIL random c=%0d got %h required %h", c, {digit_en, seg, dp, frame_done}, {e_den, e_seg, e_dp, e_fd});
            end
        end
        eof = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_shadow();
        test_blink();
        test_blank();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
